// File: rtl/pair_sum_normalizer.sv
// pair_sum_normalizer: reduces three upstream pair sums by their GCD.
// Captures a 4-beat burst (S0, S1, S2, G) and divides each Sk by G with one
// shared restoring divider (one quotient bit per cycle, MSB first). It then
// emits the three quotients as a 3-beat burst.
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    upstream beat valid
//   in_data     upstream beat payload (S0, S1, S2, G)
//   out_valid   high for three consecutive cycles per accepted burst
//   out_data    quotient Sk / G while out_valid, else 0
//   out_rem_err Sk mod G != 0 for the current beat, else 0
module pair_sum_normalizer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_rem_err
);
    localparam int BW = $clog2(W);

    typedef enum logic [1:0] {IDLE, COLLECT, DIVIDE, OUTPUT} state_t;

    state_t             state, state_n;
    logic               prev_valid;
    logic               sampled;
    logic [1:0]         cnt, cnt_n;
    logic [2:0][W-1:0]  s, s_n;
    logic [W-1:0]       g, g_n;
    logic [1:0]         op, op_n;
    logic [BW-1:0]      bit_idx, bit_n;
    logic [W-1:0]       rem, rem_n;
    logic [W-1:0]       quo, quo_n;
    logic [2:0][W-1:0]  q, q_n;
    logic [2:0]         err, err_n;
    logic [1:0]         oidx, oidx_n;
    logic               ov_n;
    logic [W-1:0]       od_n;
    logic               oe_n;

    // Divider datapath. The partial remainder always stays below the divisor,
    // so it is stored in W bits; only the shifted value needs W+1 bits.
    logic               first;
    logic [W-1:0]       opnd;
    logic [W:0]         divisor;
    logic [W:0]         r_shift;
    logic               q_bit;
    logic [W:0]         r_new;
    logic [W-1:0]       q_new;

    assign first   = bit_idx == BW'(W-1);
    assign opnd    = s[op];
    // A zero GCD divides by 1, which yields Qk = Sk with a zero remainder.
    assign divisor = (g == '0) ? (W+1)'(1) : {1'b0, g};
    assign r_shift = {(first ? W'(0) : rem), opnd[bit_idx]};
    assign q_bit   = r_shift >= divisor;
    assign r_new   = q_bit ? r_shift - divisor : r_shift;
    assign q_new   = {(first ? (W-1)'(0) : quo[W-2:0]), q_bit};

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        s_n     = s;
        g_n     = g;
        op_n    = op;
        bit_n   = bit_idx;
        rem_n   = rem;
        quo_n   = quo;
        q_n     = q;
        err_n   = err;
        oidx_n  = oidx;
        ov_n    = 1'b0;
        od_n    = '0;
        oe_n    = 1'b0;
        case (state)
            IDLE: begin
                // Start only on a rising in_valid. The sampled bit blocks a
                // start on a level that was already high when reset released.
                if (in_valid && !prev_valid && sampled) begin
                    s_n[0]  = in_data;
                    cnt_n   = 2'd1;
                    state_n = COLLECT;
                end
            end
            COLLECT: begin
                if (!in_valid) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (cnt == 2'd3) begin
                    g_n     = in_data;
                    cnt_n   = '0;
                    op_n    = '0;
                    bit_n   = BW'(W-1);
                    state_n = DIVIDE;
                end else begin
                    s_n[cnt] = in_data;
                    cnt_n    = cnt + 2'd1;
                end
            end
            DIVIDE: begin
                rem_n = r_new[W-1:0];
                quo_n = q_new;
                bit_n = bit_idx - BW'(1);
                if (bit_idx == '0) begin
                    q_n[op]   = q_new;
                    err_n[op] = r_new != '0;
                    bit_n     = BW'(W-1);
                    op_n      = op + 2'd1;
                    if (op == 2'd2) begin
                        op_n    = '0;
                        oidx_n  = '0;
                        state_n = OUTPUT;
                    end
                end
            end
            OUTPUT: begin
                // Indices 0..2 emit Q0..Q2; index 3 drops out_valid and leaves.
                ov_n   = oidx != 2'd3;
                od_n   = ov_n ? q[oidx] : '0;
                oe_n   = ov_n & err[oidx];
                oidx_n = oidx + 2'd1;
                if (oidx == 2'd3) begin
                    oidx_n  = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prev_valid  <= 1'b0;
            sampled     <= 1'b0;
            cnt         <= '0;
            s           <= '0;
            g           <= '0;
            op          <= '0;
            bit_idx     <= '0;
            rem         <= '0;
            quo         <= '0;
            q           <= '0;
            err         <= '0;
            oidx        <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_rem_err <= 1'b0;
        end else begin
            state       <= state_n;
            prev_valid  <= in_valid;
            sampled     <= 1'b1;
            cnt         <= cnt_n;
            s           <= s_n;
            g           <= g_n;
            op          <= op_n;
            bit_idx     <= bit_n;
            rem         <= rem_n;
            quo         <= quo_n;
            q           <= q_n;
            err         <= err_n;
            oidx        <= oidx_n;
            out_valid   <= ov_n;
            out_data    <= od_n;
            out_rem_err <= oe_n;
        end
    end
endmodule

// File: tb/tb_pair_sum_normalizer.sv
// tb_pair_sum_normalizer: directed bench with a division model and scoreboard.
module tb_pair_sum_normalizer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [4:0] in_data = '0;
    logic       out_valid;
    logic [4:0] out_data;
    logic       out_rem_err;

    pair_sum_normalizer #(.W(5)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_rem_err(out_rem_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];
    int         lat_q[$];
    logic [5:0] seen[$];
    int         run = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s got unexpected event want none", name);
    endtask

    // Expected {err, quotient}: plain integer division, zero GCD acts as 1.
    function automatic logic [5:0] model(input int s, input int g);
        int d;
        d = (g == 0) ? 1 : g;
        return {(s % d) != 0, 5'(s / d)};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            run = 0;
        end else if (out_valid) begin
            if (run == 0) begin
                if (lat_q.size() == 0) fail("unexpected_burst_start");
                else check("first_beat_latency", cyc - lat_q.pop_front(), 16);
            end
            run++;
            seen.push_back({out_rem_err, out_data});
            if (exp_q.size() == 0) fail("extra_beat");
            else check("beat", {out_rem_err, out_data}, exp_q.pop_front());
        end else begin
            check("idle_outputs", {out_rem_err, out_data}, 0);
            if (run != 0) check("valid_run_length", run, 3);
            run = 0;
        end
    end

    task automatic drive(input logic v, input logic [4:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 5'd0);
    endtask

    task automatic burst(input logic [4:0] s0, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [4:0] g, input bit acc);
        drive(1'b1, s0);
        drive(1'b1, s1);
        drive(1'b1, s2);
        drive(1'b1, g);
        in_valid = 1'b0;
        in_data  = '0;
        if (acc) begin
            lat_q.push_back(cyc);
            exp_q.push_back(model(s0, g));
            exp_q.push_back(model(s1, g));
            exp_q.push_back(model(s2, g));
        end
    endtask

    task automatic drain(input int n);
        idle(n);
        check("beats_outstanding", exp_q.size(), 0);
    endtask

    task automatic check_seen(input string name, input int e0, input int e1, input int e2);
        int e[3];
        e = '{e0, e1, e2};
        check({name, "_count"}, seen.size(), 3);
        for (int i = 0; i < 3; i++)
            check(name, (i < seen.size()) ? int'(seen[i]) : -1, e[i]);
    endtask

    task automatic flush();
        exp_q.delete();
        lat_q.delete();
        seen.delete();
    endtask

    initial begin
        check("model_6_4", model(6, 4), 33);
        check("model_12_4", model(12, 4), 3);
        check("model_0_0", model(0, 0), 0);
        check("model_13_1", model(13, 1), 13);
        check("model_31_31", model(31, 31), 1);

        #2 rst_n = 1'b0;
        #1 check("reset_outputs", {out_valid, out_rem_err, out_data}, 0);
        idle(3);
        rst_n = 1'b1;
        idle(3);

        seen.delete();
        burst(6, 9, 12, 3, 1);
        drain(25);
        check_seen("b_6_9_12_g3", 2, 3, 4);

        burst(7, 11, 13, 1, 1);
        drain(25);
        burst(30, 30, 30, 30, 1);
        drain(25);
        burst(0, 0, 0, 0, 1);
        drain(25);
        burst(31, 0, 31, 31, 1);
        drain(25);

        seen.delete();
        burst(6, 9, 12, 4, 1);
        drain(25);
        check_seen("b_6_9_12_g4", 33, 34, 3);

        drive(1'b1, 5);
        drive(1'b1, 7);
        drain(30);
        seen.delete();
        burst(8, 4, 12, 4, 1);
        drain(25);
        check_seen("b_8_4_12_g4", 2, 1, 3);

        burst(1, 2, 3, 1, 1);
        idle(18);
        burst(9, 9, 9, 9, 0);
        drain(25);

        burst(1, 2, 3, 1, 1);
        idle(19);
        burst(4, 6, 8, 2, 1);
        drain(40);

        burst(12, 18, 24, 6, 1);
        idle(3);
        burst(1, 1, 1, 1, 0);
        drain(25);

        burst(3, 6, 9, 3, 1);
        idle(5);
        rst_n = 1'b0;
        #1 check("reset_divide_outputs", {out_valid, out_rem_err, out_data}, 0);
        flush();
        idle(2);
        rst_n = 1'b1;
        drain(30);
        seen.delete();
        burst(10, 15, 5, 5, 1);
        drain(25);
        check_seen("b_10_15_5_g5", 2, 3, 1);

        burst(20, 10, 5, 5, 1);
        begin
            int n = 0;
            while (!out_valid && n < 40) begin
                drive(1'b0, 5'd0);
                n++;
            end
        end
        check("output_reached", out_valid, 1);
        rst_n = 1'b0;
        #1 check("reset_output_outputs", {out_valid, out_rem_err, out_data}, 0);
        flush();
        repeat (3) drive(1'b1, 5'd7);
        rst_n = 1'b1;
        repeat (6) drive(1'b1, 5'd7);
        drain(30);
        seen.delete();
        burst(5, 10, 15, 5, 1);
        drain(25);
        check_seen("b_5_10_15_g5", 1, 2, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
